// File: rtl/key_input_frontend.sv
// ---------------------------------------------------------------------------
// key_input_frontend
//
// Purpose:
//   Conditions the raw board inputs before they reach main_control and the
//   datapath.  All KEY and SW pins are brought into the clock domain with a
//   two-flop synchronizer.  Each key is debounced independently, and a
//   one-cycle pulse is produced for every debounced press.  A press of the
//   load key snapshots SW[7:0] into a capture register.  That register stays
//   stable until the consumer acknowledges it.
//
// Ports:
//   clock        in   1   system clock (CLOCK_50)
//   reset        in   1   asynchronous, active-high reset
//   key_n        in   4   raw KEY pins, active-low, asynchronous
//   sw           in  10   raw SW pins, asynchronous
//   key_level    out  4   debounced key state, 1 = pressed
//   press_pulse  out  4   one-cycle pulse per key on a debounced press
//   sw_sync      out 10   synchronized switch values
//   value_out    out  8   captured SW[7:0]
//   value_valid  out  1   value_out holds an unconsumed capture
//   value_ack    in   1   consumer accepts value_out (sampled on clock edge)
//   overrun      out  1   sticky: a capture overwrote an unacknowledged value
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive cycles a synchronized key level must differ
//                    from the accepted level before it is accepted (>= 1)
//   CNT_W            debounce counter width, must hold DEBOUNCE_CYCLES-1
//   LOAD_KEY         index of the key whose press triggers the SW capture
// ---------------------------------------------------------------------------
module key_input_frontend #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 19,
   parameter int LOAD_KEY        = 1
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] key_n,
   input  logic [9:0] sw,
   output logic [3:0] key_level,
   output logic [3:0] press_pulse,
   output logic [9:0] sw_sync,
   output logic [7:0] value_out,
   output logic       value_valid,
   input  logic       value_ack,
   output logic       overrun
);

   // The last count before a differing level is accepted.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   // Synchronizer stages
   logic [3:0]       r_key_sync_p0;
   logic [3:0]       r_key_sync_p1;
   logic [9:0]       r_sw_sync_p0;
   logic [9:0]       r_sw_sync_p1;

   // Debounce state. r_stable holds the accepted, active-low key level.
   logic [3:0]       r_stable;
   logic [CNT_W-1:0] r_cnt [4];
   logic [3:0]       w_stable_nxt;
   logic [CNT_W-1:0] w_cnt_nxt [4];

   // Press detection and capture handshake
   logic [3:0]       w_fall;
   logic             w_cap;
   logic             w_overwrite;
   logic             w_consume;
   logic [3:0]       r_press;
   logic [7:0]       r_value;
   logic             r_valid;
   logic             r_overrun;

   // ------------------------------------------------------------------
   // Stage p0 -> p1: two-flop synchronizers.
   // Keys idle high (released), so the key stages reset to all ones. A key
   // held through reset is then seen as a fresh press afterwards.
   // ------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_key_sync_p0 <= 4'b1111;
         r_key_sync_p1 <= 4'b1111;
         r_sw_sync_p0  <= '0;
         r_sw_sync_p1  <= '0;
      end else begin
         r_key_sync_p0 <= key_n;
         r_key_sync_p1 <= r_key_sync_p0;
         r_sw_sync_p0  <= sw;
         r_sw_sync_p1  <= r_sw_sync_p0;
      end
   end

   assign sw_sync = r_sw_sync_p1;

   // ------------------------------------------------------------------
   // Debounce next-state. Each key is independent.
   // The counter runs only while the synchronized level disagrees with the
   // accepted level. Any agreement, such as a bounce back, clears it. The
   // new level is accepted on the cycle the counter is already at CNT_LAST.
   // That requires DEBOUNCE_CYCLES consecutive disagreeing samples.
   // ------------------------------------------------------------------
   always_comb begin
      w_stable_nxt = r_stable;
      for (int i = 0; i < 4; i++) begin
         w_cnt_nxt[i] = '0;
         if (r_key_sync_p1[i] != r_stable[i]) begin
            if (r_cnt[i] == CNT_LAST) begin
               w_stable_nxt[i] = r_key_sync_p1[i];
            end else begin
               w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stable <= 4'b1111;
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] <= '0;
         end
      end else begin
         r_stable <= w_stable_nxt;
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] <= w_cnt_nxt[i];
         end
      end
   end

   assign key_level = ~r_stable;

   // ------------------------------------------------------------------
   // Press pulses. A press is the accepted level going 1->0 (active-low).
   // The pulse is registered, so it lines up with the first cycle in which
   // key_level reads pressed.
   // ------------------------------------------------------------------
   assign w_fall = r_stable & ~w_stable_nxt;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_press <= '0;
      end else begin
         r_press <= w_fall;
      end
   end

   assign press_pulse = r_press;

   // ------------------------------------------------------------------
   // Capture handshake.
   // On a load-key press, capture the pre-edge synchronized switches.
   // - A capture always wins over a same-cycle ack: the new value is left
   //   valid.
   // - A capture counts as an overrun only if the old value was still
   //   unacknowledged.
   // - An ack while nothing is valid has no effect.
   // ------------------------------------------------------------------
   assign w_cap       = w_fall[LOAD_KEY];
   assign w_overwrite = w_cap && r_valid && !value_ack;
   assign w_consume   = !w_cap && r_valid && value_ack;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_value   <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_cap) begin
            r_value <= r_sw_sync_p1[7:0];
            r_valid <= 1'b1;
         end else if (w_consume) begin
            r_valid <= 1'b0;
         end
         // overrun is sticky until reset
         if (w_overwrite) begin
            r_overrun <= 1'b1;
         end
      end
   end

   assign value_out   = r_value;
   assign value_valid = r_valid;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_key_input_frontend.sv
module tb_key_input_frontend;

   localparam int D  = 4;
   localparam int LK = 1;

   logic       clock;
   logic       reset;
   logic [3:0] key_n;
   logic [9:0] sw;
   logic       value_ack;
   logic [3:0] key_level;
   logic [3:0] press_pulse;
   logic [9:0] sw_sync;
   logic [7:0] value_out;
   logic       value_valid;
   logic       overrun;

   int n_cmp  = 0;
   int n_fail = 0;

   key_input_frontend #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3),
      .LOAD_KEY       (LK)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .key_n      (key_n),
      .sw         (sw),
      .key_level  (key_level),
      .press_pulse(press_pulse),
      .sw_sync    (sw_sync),
      .value_out  (value_out),
      .value_valid(value_valid),
      .value_ack  (value_ack),
      .overrun    (overrun)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- behavioural reference model ----------------
   // The model keeps a 2-deep delay queue for the synchronizers.
   // It also keeps a window of the last D synchronized key samples.
   // A key's accepted level flips when every sample in the window disagrees
   // with it.
   logic [3:0] m_stable;
   logic [3:0] m_pls;
   logic [9:0] m_sws;
   logic [7:0] m_vo;
   logic       m_vv;
   logic       m_ov;
   logic [3:0] m_kq[$];
   logic [9:0] m_sq[$];
   logic [3:0] m_hist[$];

   task automatic model_reset();
      m_kq = '{4'hF, 4'hF};
      m_sq = '{10'h000, 10'h000};
      m_hist.delete();
      m_stable = 4'hF;
      m_pls = 4'h0;
      m_sws = 10'h000;
      m_vo = 8'h00;
      m_vv = 1'b0;
      m_ov = 1'b0;
   endtask

   task automatic model_edge(input logic [3:0] kn, input logic [9:0] sv, input logic ack);
      logic [3:0] samp;
      logic [9:0] swpre;
      logic [3:0] nst;
      logic [3:0] fell;
      bit         all_diff;
      samp = m_kq.pop_front();
      m_kq.push_back(kn);
      swpre = m_sq.pop_front();
      m_sq.push_back(sv);
      m_sws = m_sq[0];
      m_hist.push_back(samp);
      if (m_hist.size() > D) m_hist.delete(0);
      nst = m_stable;
      for (int i = 0; i < 4; i++) begin
         if (m_hist.size() == D) begin
            all_diff = 1'b1;
            for (int j = 0; j < D; j++)
               if (m_hist[j][i] == m_stable[i]) all_diff = 1'b0;
            if (all_diff) nst[i] = ~m_stable[i];
         end
      end
      fell = m_stable & ~nst;
      m_pls = fell;
      if (fell[LK]) begin
         if (m_vv && !ack) m_ov = 1'b1;
         m_vo = swpre[7:0];
         m_vv = 1'b1;
      end else if (m_vv && ack) begin
         m_vv = 1'b0;
      end
      m_stable = nst;
   endtask

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // One rising edge. Outputs are sampled 1 time unit later.
   task automatic tick();
      logic [3:0] kn;
      logic [9:0] sv;
      logic       a;
      logic       r;
      kn = key_n;
      sv = sw;
      a = value_ack;
      r = reset;
      @(posedge clock);
      #1;
      if (r) model_reset();
      else   model_edge(kn, sv, a);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      tick();
      reset = 1'b0;
   endtask

   typedef struct {
      logic [3:0] kn;
      logic [9:0] sv;
      logic       ack;
      logic [3:0] lvl;
      logic [3:0] pls;
      logic [9:0] sws;
      logic [7:0] vo;
      logic       vv;
      logic       ov;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic [3:0] kn, input logic [9:0] sv, input logic ack,
                      input logic [3:0] lvl, input logic [3:0] pls, input logic [9:0] sws,
                      input logic [7:0] vo, input logic vv, input logic ov);
      vec_t v;
      v = '{kn, sv, ack, lvl, pls, sws, vo, vv, ov};
      tbl.push_back(v);
   endtask

   int npulse;
   int pedge;

   initial begin
      // Table: key0 press/release, then key1 capture and ack.
      repeat (5) add(4'b1110, 10'h000, 1'b0, 4'b0000, 4'b0000, 10'h000, 8'h00, 1'b0, 1'b0);
      add(4'b1110, 10'h000, 1'b0, 4'b0001, 4'b0001, 10'h000, 8'h00, 1'b0, 1'b0);
      repeat (5) add(4'b1111, 10'h000, 1'b0, 4'b0001, 4'b0000, 10'h000, 8'h00, 1'b0, 1'b0);
      repeat (2) add(4'b1111, 10'h000, 1'b0, 4'b0000, 4'b0000, 10'h000, 8'h00, 1'b0, 1'b0);
      add(4'b1101, 10'h0A5, 1'b0, 4'b0000, 4'b0000, 10'h000, 8'h00, 1'b0, 1'b0);
      repeat (4) add(4'b1101, 10'h0A5, 1'b0, 4'b0000, 4'b0000, 10'h0A5, 8'h00, 1'b0, 1'b0);
      add(4'b1101, 10'h0A5, 1'b0, 4'b0010, 4'b0010, 10'h0A5, 8'hA5, 1'b1, 1'b0);
      add(4'b1101, 10'h0A5, 1'b1, 4'b0010, 4'b0000, 10'h0A5, 8'hA5, 1'b0, 1'b0);
      add(4'b1101, 10'h0A5, 1'b0, 4'b0010, 4'b0000, 10'h0A5, 8'hA5, 1'b0, 1'b0);
      repeat (2) add(4'b1111, 10'h0A5, 1'b0, 4'b0010, 4'b0000, 10'h0A5, 8'hA5, 1'b0, 1'b0);

      // ---- reset values ----
      reset = 1'b1;
      key_n = 4'hF;
      sw = 10'h3FF;
      value_ack = 1'b0;
      model_reset();
      #2;
      chk("rst_key_level", 32'(key_level), 32'h0);
      chk("rst_press_pulse", 32'(press_pulse), 32'h0);
      chk("rst_sw_sync", 32'(sw_sync), 32'h0);
      chk("rst_value_out", 32'(value_out), 32'h0);
      chk("rst_value_valid", 32'(value_valid), 32'h0);
      chk("rst_overrun", 32'(overrun), 32'h0);
      tick();
      reset = 1'b0;
      tick();
      chk("sw_sync_after_1_edge", 32'(sw_sync), 32'h0);
      tick();
      chk("sw_sync_after_2_edges", 32'(sw_sync), 32'h3FF);
      chk("key_level_idle", 32'(key_level), 32'h0);

      // ---- table-driven press / capture / ack ----
      sw = 10'h000;
      repeat (3) tick();
      foreach (tbl[i]) begin
         key_n = tbl[i].kn;
         sw = tbl[i].sv;
         value_ack = tbl[i].ack;
         tick();
         chk($sformatf("tbl[%0d].key_level", i), 32'(key_level), 32'(tbl[i].lvl));
         chk($sformatf("tbl[%0d].press_pulse", i), 32'(press_pulse), 32'(tbl[i].pls));
         chk($sformatf("tbl[%0d].sw_sync", i), 32'(sw_sync), 32'(tbl[i].sws));
         chk($sformatf("tbl[%0d].value_out", i), 32'(value_out), 32'(tbl[i].vo));
         chk($sformatf("tbl[%0d].value_valid", i), 32'(value_valid), 32'(tbl[i].vv));
         chk($sformatf("tbl[%0d].overrun", i), 32'(overrun), 32'(tbl[i].ov));
      end
      value_ack = 1'b0;

      // ---- bounce on key 3: low 3, high 1, then low steadily ----
      key_n = 4'hF;
      sw = 10'h000;
      do_reset();
      npulse = 0;
      pedge = 0;
      for (int k = 1; k <= 20; k++) begin
         key_n[3] = (k == 4) ? 1'b1 : 1'b0;
         tick();
         if (press_pulse[3]) begin
            npulse++;
            pedge = k;
         end
      end
      chk("bounce_pulse_count", 32'(npulse), 32'd1);
      chk("bounce_pulse_edge", 32'(pedge), 32'd10);

      // ---- overrun ----
      key_n = 4'hF;
      do_reset();
      sw = 10'h011;
      repeat (3) tick();
      key_n = 4'b1101;
      repeat (6) tick();
      chk("ovr_first_pulse", 32'(press_pulse), 32'h2);
      chk("ovr_first_value", 32'(value_out), 32'h11);
      chk("ovr_first_valid", 32'(value_valid), 32'h1);
      chk("ovr_first_overrun", 32'(overrun), 32'h0);
      key_n = 4'hF;
      repeat (8) tick();
      sw = 10'h022;
      key_n = 4'b1101;
      repeat (6) tick();
      chk("ovr_second_value", 32'(value_out), 32'h22);
      chk("ovr_second_valid", 32'(value_valid), 32'h1);
      chk("ovr_second_overrun", 32'(overrun), 32'h1);
      value_ack = 1'b1;
      tick();
      value_ack = 1'b0;
      chk("ovr_ack_valid", 32'(value_valid), 32'h0);
      chk("ovr_ack_overrun_sticky", 32'(overrun), 32'h1);
      chk("ovr_ack_value_held", 32'(value_out), 32'h22);
      reset = 1'b1;
      model_reset();
      #2;
      chk("ovr_reset_clears", 32'(overrun), 32'h0);
      tick();
      reset = 1'b0;

      // ---- ack on the same edge as a new capture ----
      key_n = 4'hF;
      do_reset();
      sw = 10'h033;
      repeat (2) tick();
      key_n = 4'b1101;
      repeat (6) tick();
      chk("simul_first_value", 32'(value_out), 32'h33);
      chk("simul_first_valid", 32'(value_valid), 32'h1);
      key_n = 4'hF;
      repeat (8) tick();
      sw = 10'h07E;
      key_n = 4'b1101;
      repeat (5) tick();
      value_ack = 1'b1;
      tick();
      value_ack = 1'b0;
      chk("simul_pulse", 32'(press_pulse), 32'h2);
      chk("simul_value", 32'(value_out), 32'h7E);
      chk("simul_valid", 32'(value_valid), 32'h1);
      chk("simul_overrun", 32'(overrun), 32'h0);
      tick();
      chk("simul_valid_kept", 32'(value_valid), 32'h1);

      // ---- reset in the middle of a debounce count ----
      key_n = 4'hF;
      do_reset();
      key_n = 4'b1011;
      repeat (4) tick();
      chk("midcount_no_pulse", 32'(press_pulse), 32'h0);
      reset = 1'b1;
      model_reset();
      #2;
      chk("midcount_rst_level", 32'(key_level), 32'h0);
      chk("midcount_rst_pulse", 32'(press_pulse), 32'h0);
      tick();
      reset = 1'b0;
      npulse = 0;
      pedge = 0;
      for (int k = 1; k <= 12; k++) begin
         tick();
         if (press_pulse[2]) begin
            npulse++;
            pedge = k;
         end
      end
      chk("midcount_pulse_count", 32'(npulse), 32'd1);
      chk("midcount_pulse_edge", 32'(pedge), 32'd6);
      chk("midcount_level_after", 32'(key_level), 32'h4);

      // ---- randomized run against the reference model ----
      key_n = 4'hF;
      sw = 10'h000;
      value_ack = 1'b0;
      do_reset();
      for (int n = 0; n < 2000; n++) begin
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 5) == 0) key_n[i] = ~key_n[i];
         if ($urandom_range(0, 7) == 0) sw = 10'($urandom);
         value_ack = ($urandom_range(0, 3) == 0);
         reset = ($urandom_range(0, 299) == 0);
         tick();
         chk($sformatf("rand[%0d]", n),
             32'({key_level, press_pulse, sw_sync, value_out, value_valid, overrun}),
             32'({~m_stable, m_pls, m_sws, m_vo, m_vv, m_ov}));
      end
      reset = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
